// File: rtl/riscv_muldiv_unit.sv
// riscv_muldiv_unit
//   Iterative RV32M multiply/divide unit for the EX stage. One operation per
//   request handshake; multiply is shift-add on a 2*WIDTH product register,
//   divide is restoring division on operand magnitudes with sign correction
//   applied on the final edge. Divide-by-zero and signed overflow bypass the
//   iteration and complete one cycle after the accept.
// Ports
//   clk, rst          clock, synchronous active-high reset
//   flush             synchronous abort of the op in flight (below rst)
//   in_valid/in_ready request handshake; in_ready is high only in IDLE
//   op, a, b, tag_in  funct3 op code, operands, request tag
//   out_valid/out_ready response handshake; out_valid is high only in DONE
//   result, tag_out   response data and tag
//   zero, negative    flags of the final result
//   div_by_zero       divide op with b == 0
//   div_overflow      DIV/REM with MIN_INT / -1
//   busy              unit is not IDLE
// Handshake: a transfer happens on a rising edge where valid && ready are both
//   high. The producer holds its data stable until then; the unit holds
//   result/tag_out/flags stable while out_valid && !out_ready.
module riscv_muldiv_unit #(
  parameter int WIDTH     = 32,
  parameter int TAG_WIDTH = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2:0]           op,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic [TAG_WIDTH-1:0] tag_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     result,
  output logic [TAG_WIDTH-1:0] tag_out,
  output logic                 zero,
  output logic                 negative,
  output logic                 div_by_zero,
  output logic                 div_overflow,
  output logic                 busy
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] MIN_INT = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t                 state;
  logic [2:0]             op_q;
  logic                   neg_q;   // sign to apply to the final result
  logic [WIDTH-1:0]       mcand;   // multiplicand (mul) or divisor (div)
  logic [2*WIDTH-1:0]     prod;    // {acc/remainder, multiplier/quotient}
  logic [CW-1:0]          cnt;

  // State is visible through the handshake outputs.
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

  // Request decode
  logic             is_div, sgn_a, sgn_b, a_neg, b_neg, dz_in, ov_in, fast;
  logic [WIDTH-1:0] a_mag, b_mag, fast_res;

  always_comb begin
    is_div   = op[2];
    sgn_a    = (op == 3'd1) || (op == 3'd2) || (op == 3'd4) || (op == 3'd6);
    sgn_b    = (op == 3'd1) || (op == 3'd4) || (op == 3'd6);
    a_neg    = sgn_a && a[WIDTH-1];
    b_neg    = sgn_b && b[WIDTH-1];
    a_mag    = a_neg ? -a : a;
    b_mag    = b_neg ? -b : b;
    dz_in    = is_div && (b == '0);
    // op[0]==0 selects the signed DIV/REM pair
    ov_in    = is_div && !op[0] && (a == MIN_INT) && (b == '1);
    fast     = dz_in || ov_in;
    fast_res = '0;
    if (dz_in)      fast_res = op[1] ? a : '1;
    else if (ov_in) fast_res = op[1] ? '0 : MIN_INT;
  end

  // One iteration step
  logic [WIDTH:0]     sum, rem_sh;
  logic [WIDTH-1:0]   diff;
  logic               ge;
  logic [2*WIDTH-1:0] mul_nxt, div_nxt, prod_nxt, prod_sgn;
  logic [WIDTH-1:0]   fin_res;

  always_comb begin
    sum     = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mcand} : '0);
    mul_nxt = {sum, prod[WIDTH-1:1]};
    rem_sh  = prod[2*WIDTH-1:WIDTH-1];
    ge      = (rem_sh >= {1'b0, mcand});
    // Only used when ge, so the difference is below the divisor and fits WIDTH bits.
    diff    = rem_sh[WIDTH-1:0] - mcand;
    div_nxt = ge ? {diff, prod[WIDTH-2:0], 1'b1}
                 : {rem_sh[WIDTH-1:0], prod[WIDTH-2:0], 1'b0};
    prod_nxt = op_q[2] ? div_nxt : mul_nxt;
    prod_sgn = neg_q ? -prod_nxt : prod_nxt;
    fin_res  = '0;
    case (op_q)
      3'd0:         fin_res = prod_sgn[WIDTH-1:0];
      3'd1, 3'd2,
      3'd3:         fin_res = prod_sgn[2*WIDTH-1:WIDTH];
      3'd4, 3'd5:   fin_res = neg_q ? -prod_nxt[WIDTH-1:0] : prod_nxt[WIDTH-1:0];
      default:      fin_res = neg_q ? -prod_nxt[2*WIDTH-1:WIDTH] : prod_nxt[2*WIDTH-1:WIDTH];
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state        <= IDLE;
      op_q         <= '0;
      neg_q        <= 1'b0;
      mcand        <= '0;
      prod         <= '0;
      cnt          <= '0;
      result       <= '0;
      tag_out      <= '0;
      zero         <= 1'b0;
      negative     <= 1'b0;
      div_by_zero  <= 1'b0;
      div_overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            op_q    <= op;
            tag_out <= tag_in;
            // Remainder follows the dividend; everything else follows a^b.
            neg_q   <= (is_div && op[1]) ? a_neg : (a_neg ^ b_neg);
            mcand   <= is_div ? b_mag : a_mag;
            prod    <= {{WIDTH{1'b0}}, (is_div ? a_mag : b_mag)};
            cnt     <= CW'(WIDTH);
            if (fast) begin
              state        <= DONE;
              result       <= fast_res;
              zero         <= (fast_res == '0);
              negative     <= fast_res[WIDTH-1];
              div_by_zero  <= dz_in;
              div_overflow <= ov_in;
            end else begin
              state <= CALC;
            end
          end
        end
        CALC: begin
          prod <= prod_nxt;
          cnt  <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            state        <= DONE;
            result       <= fin_res;
            zero         <= (fin_res == '0);
            negative     <= fin_res[WIDTH-1];
            div_by_zero  <= 1'b0;
            div_overflow <= 1'b0;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_muldiv_unit.sv
module tb_riscv_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic [4:0]  tag_in;
  logic        in_ready, out_valid, zero, negative, div_by_zero, div_overflow, busy;
  logic [31:0] result;
  logic [4:0]  tag_out;

  riscv_muldiv_unit #(.WIDTH(32), .TAG_WIDTH(5)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .tag_in(tag_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .tag_out(tag_out),
    .zero(zero), .negative(negative),
    .div_by_zero(div_by_zero), .div_overflow(div_overflow),
    .busy(busy)
  );

  // clock / reset
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // flags packed as {zero, negative, div_by_zero, div_overflow}
  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [3:0]  flags;
    int          lat;
  } vec_t;

  vec_t vecs[20];

  // driver: present request at a negedge, return right after the accept edge
  task automatic start_op(input logic [2:0] op_i, input logic [31:0] a_i, input logic [31:0] b_i,
                          input logic [4:0] tag_i);
    @(negedge clk);
    check("in_ready_pre", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1; op = op_i; a = a_i; b = b_i; tag_in = tag_i;
    @(posedge clk);
    #1;
    // garbage after the accept edge must not affect the op
    in_valid = 1'b0;
    op = 3'($urandom_range(0, 7)); a = $urandom; b = $urandom; tag_in = 5'($urandom_range(0, 31));
  endtask

  // edges counted including the accept edge; -1 on timeout
  task automatic wait_done(output int lat);
    lat = 1;
    forever begin
      @(negedge clk);
      if (out_valid) break;
      lat++;
      if (lat > 100) begin lat = -1; break; end
      @(posedge clk);
    end
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    check("release_idle", {30'd0, in_ready, out_valid}, 32'd2);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_result"}, result, 32'd0);
    check({name, "_misc"},
          {20'd0, tag_out, zero, negative, div_by_zero, div_overflow, in_ready, out_valid, busy},
          {20'd0, 5'd0, 4'd0, 1'b1, 1'b0, 1'b0});
  endtask

  int lat;
  logic seen;

  initial begin
    vecs[0]  = '{3'd0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 4'b0100, 33};
    vecs[1]  = '{3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 4'b0000, 33};
    vecs[2]  = '{3'd3, 32'h80000000, 32'h80000000, 32'h40000000, 4'b0000, 33};
    vecs[3]  = '{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'b0100, 33};
    vecs[4]  = '{3'd4, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 4'b0100, 33};
    vecs[5]  = '{3'd6, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 4'b0100, 33};
    vecs[6]  = '{3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 4'b0101, 1};
    vecs[7]  = '{3'd5, 32'd5,        32'd0,        32'hFFFFFFFF, 4'b0110, 1};
    vecs[8]  = '{3'd7, 32'd5,        32'd0,        32'd5,        4'b0010, 1};
    vecs[9]  = '{3'd0, 32'd0,        32'd12345,    32'd0,        4'b1000, 33};
    vecs[10] = '{3'd5, 32'd100,      32'd7,        32'd14,       4'b0000, 33};
    vecs[11] = '{3'd7, 32'd100,      32'd7,        32'd2,        4'b0000, 33};
    vecs[12] = '{3'd6, 32'h80000000, 32'hFFFFFFFF, 32'd0,        4'b1001, 1};
    vecs[13] = '{3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 4'b0100, 33};
    vecs[14] = '{3'd4, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 4'b0100, 33};
    vecs[15] = '{3'd6, 32'd7,        32'hFFFFFFFE, 32'd1,        4'b0000, 33};
    vecs[16] = '{3'd0, 32'h12345678, 32'h10,       32'h23456780, 4'b0000, 33};
    vecs[17] = '{3'd4, 32'd0,        32'd5,        32'd0,        4'b1000, 33};
    vecs[18] = '{3'd4, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFF, 4'b0110, 1};
    vecs[19] = '{3'd6, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 4'b0110, 1};

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    op = '0; a = '0; b = '0; tag_in = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    // table-driven vectors
    for (int i = 0; i < 20; i++) begin
      start_op(vecs[i].op, vecs[i].a, vecs[i].b, 5'(i + 3));
      wait_done(lat);
      check($sformatf("v%0d_result", i), result, vecs[i].res);
      check($sformatf("v%0d_tag", i), {27'd0, tag_out}, {27'd0, 5'(i + 3)});
      check($sformatf("v%0d_flags", i), {28'd0, zero, negative, div_by_zero, div_overflow},
            {28'd0, vecs[i].flags});
      check($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
      release_out();
    end

    // backpressure: response must stay put for 10 cycles
    start_op(3'd0, 32'd3, 32'd5, 5'd21);
    wait_done(lat);
    for (int k = 0; k < 10; k++) begin
      check("bp_result", result, 32'd15);
      check("bp_hold", {24'd0, tag_out, in_ready, out_valid, busy}, {24'd0, 5'd21, 3'b011});
      @(negedge clk);
    end
    release_out();

    // flush in CALC, then idle-cycle flush beats a simultaneous request
    start_op(3'd5, 32'd1000, 32'd3, 5'd9);
    repeat (11) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    check_reset_outputs("flush");
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      seen = seen | out_valid;
    end
    check("flush_no_valid", {31'd0, seen}, 32'd0);
    in_valid = 1'b1; flush = 1'b1; op = 3'd0; a = 32'd2; b = 32'd2;
    @(posedge clk);
    #1 in_valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    check("flush_beats_accept", {31'd0, busy}, 32'd0);
    start_op(3'd5, 32'd1000, 32'd3, 5'd10);
    wait_done(lat);
    check("post_flush_result", result, 32'd333);
    check("post_flush_latency", 32'(lat), 32'd33);
    release_out();

    // reset mid-CALC, and reset beating a simultaneous request
    start_op(3'd0, 32'd6, 32'd7, 5'd11);
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check_reset_outputs("midrst");
    start_op(3'd6, 32'hFFFFFFEC, 32'd6, 5'd12);
    wait_done(lat);
    check("post_rst_result", result, 32'hFFFFFFFE);
    check("post_rst_tag", {27'd0, tag_out}, 32'd12);
    check("post_rst_latency", 32'(lat), 32'd33);
    release_out();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
